ram16_bus_bridge: RTL and testbench

Adapter between the RS5 core's 32-bit byte-addressed data port and the 16-bit-wide simulation RAM (`RAM_mem_16b` style: one halfword written per access, two consecutive halfwords read per access with 1-cycle latency). It converts word, halfword and byte stores into one or two halfword writes, using read-modify-write where a halfword is only partially enabled. It also assembles 32-bit load data from the RAM's dual read outputs, and stalls the core through a ready/ack handshake.

---
 rtl/ram16_bus_bridge_pkg.sv | 31 +++
 rtl/ram16_bus_bridge.sv | 199 +++++++++++++++++++
 tb/tb_ram16_bus_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ram16_bus_bridge_pkg.sv
// rtl/ram16_bus_bridge_pkg.sv - state/half-kind types and byte-merge helper for the 16-bit RAM bridge
package ram16_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        WR_HI = 2'd2
    } ram16_bridge_state_e;

    typedef enum logic [1:0] {
        HALF_NONE    = 2'd0,
        HALF_FULL    = 2'd1,
        HALF_PARTIAL = 2'd2
    } half_kind_e;

    function automatic half_kind_e classify_half(input logic [1:0] be2);
        half_kind_e k;
        k = HALF_PARTIAL;
        if (be2 == 2'b00) k = HALF_NONE;
        else if (be2 == 2'b11) k = HALF_FULL;
        return k;
    endfunction

    function automatic logic [15:0] merge_half(input logic [15:0] old16,
                                               input logic [15:0] new16,
                                               input logic [1:0]  be2);
        return {be2[1] ? new16[15:8] : old16[15:8],
                be2[0] ? new16[7:0]  : old16[7:0]};
    endfunction

endpackage

// File: rtl/ram16_bus_bridge.sv
// rtl/ram16_bus_bridge.sv - 32-bit core data port to 16-bit RAM bridge; RAM16_BRIDGE_RMW_EN enables partial-half read-modify-write
module ram16_bus_bridge
    import ram16_bus_bridge_pkg::*;
#(
    parameter  int MEM_WIDTH = 65536,
    localparam int AW        = $clog2(MEM_WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   data_i,
    output logic          ready_o,
    output logic          ack_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_data_o,
    input  logic [31:0]   ram_data_a_i,
    input  logic [31:0]   ram_data_b_i
);

    ram16_bridge_state_e state_q, state_d;

    logic [3:0]    we_q;
    logic [AW-1:0] h_q;
    logic [31:0]   data_q;
    logic          oor_q;
    logic          rd_q;
    logic [15:0]   b_q;
    logic          ack_q;
    logic          err_q;

    logic          finish;
    logic          err_c;
    logic [15:0]   wdata16;

    logic [AW-1:0] h_in;
    logic          oor_in;
    logic          is_read_in;
    logic          any_partial_in;
    half_kind_e    lo_k_in, hi_k_in, lo_k_q, hi_k_q;
    logic          accept;

    assign h_in           = addr_i[AW:1];
    assign oor_in         = (h_in == AW'(MEM_WIDTH - 1));
    assign is_read_in     = (we_i == 4'b0000);
    assign lo_k_in        = classify_half(we_i[1:0]);
    assign hi_k_in        = classify_half(we_i[3:2]);
    assign any_partial_in = (lo_k_in == HALF_PARTIAL) || (hi_k_in == HALF_PARTIAL);
    assign lo_k_q         = classify_half(we_q[1:0]);
    assign hi_k_q         = classify_half(we_q[3:2]);
    assign accept         = req_i && (state_q == IDLE);

    logic unused_bits;
    assign unused_bits = ^{addr_i[0], addr_i[31:AW+1], ram_data_a_i[31:16], ram_data_b_i[31:16]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i && !is_read_in) begin
                    if (any_partial_in) begin
`ifdef RAM16_BRIDGE_RMW_EN
                        state_d = MERGE;
`else
                        state_d = IDLE;
`endif
                    end else if (lo_k_in == HALF_FULL && hi_k_in == HALF_FULL) begin
                        state_d = WR_HI;
                    end
                end
            end
`ifdef RAM16_BRIDGE_RMW_EN
            MERGE:   state_d = (lo_k_q != HALF_NONE && hi_k_q != HALF_NONE) ? WR_HI : IDLE;
`endif
            WR_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // High-half writes at the last halfword are dropped and flagged rather than wrapped to 0.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        wdata16    = '0;
        finish     = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (is_read_in) begin
                        ram_en_o   = 1'b1;
                        ram_addr_o = h_in;
                        finish     = 1'b1;
                    end else if (any_partial_in) begin
`ifdef RAM16_BRIDGE_RMW_EN
                        ram_en_o   = 1'b1;
                        ram_addr_o = h_in;
`else
                        finish     = 1'b1;
                        err_c      = 1'b1;
`endif
                    end else if (lo_k_in == HALF_FULL) begin
                        ram_en_o   = 1'b1;
                        ram_we_o   = 1'b1;
                        ram_addr_o = h_in;
                        wdata16    = data_i[15:0];
                        finish     = (hi_k_in == HALF_NONE);
                    end else begin
                        finish = 1'b1;
                        if (oor_in) begin
                            err_c = 1'b1;
                        end else begin
                            ram_en_o   = 1'b1;
                            ram_we_o   = 1'b1;
                            ram_addr_o = h_in + AW'(1);
                            wdata16    = data_i[31:16];
                        end
                    end
                end
            end
`ifdef RAM16_BRIDGE_RMW_EN
            MERGE: begin
                if (lo_k_q != HALF_NONE) begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_addr_o = h_q;
                    wdata16    = merge_half(ram_data_a_i[15:0], data_q[15:0], we_q[1:0]);
                    finish     = (hi_k_q == HALF_NONE);
                end else begin
                    finish = 1'b1;
                    if (oor_q) begin
                        err_c = 1'b1;
                    end else begin
                        ram_en_o   = 1'b1;
                        ram_we_o   = 1'b1;
                        ram_addr_o = h_q + AW'(1);
                        wdata16    = merge_half(ram_data_b_i[15:0], data_q[31:16], we_q[3:2]);
                    end
                end
            end
`endif
            WR_HI: begin
                finish = 1'b1;
                if (oor_q) begin
                    err_c = 1'b1;
                end else begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_addr_o = h_q + AW'(1);
                    wdata16    = merge_half(b_q, data_q[31:16], we_q[3:2]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= '0;
            h_q    <= '0;
            data_q <= '0;
            oor_q  <= 1'b0;
            rd_q   <= 1'b0;
            b_q    <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ack_q <= finish;
            err_q <= err_c;
            if (accept) begin
                we_q   <= we_i;
                h_q    <= h_in;
                data_q <= data_i;
                oor_q  <= oor_in;
                rd_q   <= is_read_in;
            end
            if (state_q == MERGE) b_q <= ram_data_b_i[15:0];
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign ram_data_o = {16'h0000, wdata16};
    assign rdata_o    = (ack_q && rd_q) ? {oor_q ? 16'h0000 : ram_data_b_i[15:0], ram_data_a_i[15:0]}
                                        : 32'h0;

endmodule

// File: tb/tb_ram16_bus_bridge.sv
// tb/tb_ram16_bus_bridge.sv - directed vector bench for ram16_bus_bridge with a 16-bit dual-read RAM model
module tb_ram16_bus_bridge;

    localparam int MEMW = 256;
    localparam int AW   = 8;
`ifdef RAM16_BRIDGE_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req;
    logic [3:0]    we;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic          ready_o, ack_o, err_o;
    logic [31:0]   rdata_o;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_a = 32'h0;
    logic [31:0]   ram_b = 32'h0;
    logic [15:0]   mem [0:MEMW-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram16_bus_bridge #(.MEM_WIDTH(MEMW)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .we_i(we), .addr_i(addr), .data_i(data),
        .ready_o(ready_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
        .ram_data_a_i(ram_a), .ram_data_b_i(ram_b)
    );

    // Upper read bits carry junk so the bridge must ignore them.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata[15:0];
            ram_a <= {16'hA5A5, mem[ram_addr]};
            ram_b <= {16'h5A5A, mem[ram_addr + 8'd1]};
        end
    end

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                                input int l, input logic e, input logic [31:0] r);
        vec_t v;
        v.we = w; v.addr = a; v.data = d; v.lat = l; v.err = e; v.rdata = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the bridge in IDLE; returns at the negedge of the ack cycle.
    task automatic run(input vec_t v, input int idx);
        int   n;
        logic got;
        we = v.we; addr = v.addr; data = v.data; req = 1'b1;
        chk($sformatf("v%0d_ready_at_accept", idx), {31'h0, ready_o}, 32'h1);
        @(posedge clk); #1;
        req = 1'b0; we = 4'h0; addr = 32'h0; data = 32'h0;
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (ack_o) got = 1'b1;
            else chk($sformatf("v%0d_busy_ready_c%0d", idx, n), {31'h0, ready_o}, 32'h0);
        end
        chk($sformatf("v%0d_latency", idx), got ? n : 99, v.lat);
        if (got) begin
            chk($sformatf("v%0d_err", idx), {31'h0, err_o}, {31'h0, v.err});
            chk($sformatf("v%0d_ready_at_ack", idx), {31'h0, ready_o}, 32'h1);
            if (v.we == 4'h0) chk($sformatf("v%0d_rdata", idx), rdata_o, v.rdata);
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; we = 4'h0; addr = 32'h0; data = 32'h0;

        vecs.push_back(mk(4'b1111, 32'h000, 32'h76543210, 2, 1'b0, 32'h0));
        vecs.push_back(mk(4'b1111, 32'h010, 32'hDEADBEEF, 2, 1'b0, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h010, 32'h0,        1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(4'b0101, 32'h010, 32'h00AA0055, RMW ? 3 : 1, !RMW, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h010, 32'h0,        1, 1'b0, RMW ? 32'hDEAABE55 : 32'hDEADBEEF));
        vecs.push_back(mk(4'b0001, 32'h010, 32'h000000FF, RMW ? 2 : 1, !RMW, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h010, 32'h0,        1, 1'b0, RMW ? 32'hDEAABEFF : 32'hDEADBEEF));
        vecs.push_back(mk(4'b0111, 32'h010, 32'h00CC1234, RMW ? 3 : 1, !RMW, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h010, 32'h0,        1, 1'b0, RMW ? 32'hDECC1234 : 32'hDEADBEEF));
        vecs.push_back(mk(4'b1000, 32'h010, 32'hAB000000, RMW ? 2 : 1, !RMW, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h010, 32'h0,        1, 1'b0, RMW ? 32'hABCC1234 : 32'hDEADBEEF));
        vecs.push_back(mk(4'b1111, 32'h020, 32'hAAAA5555, 2, 1'b0, 32'h0));
        vecs.push_back(mk(4'b1100, 32'h020, 32'h12340000, 1, 1'b0, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h020, 32'h0,        1, 1'b0, 32'h12345555));
        vecs.push_back(mk(4'b0011, 32'h020, 32'h0000BEEF, 1, 1'b0, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h020, 32'h0,        1, 1'b0, 32'h1234BEEF));
        vecs.push_back(mk(4'b1111, 32'h1FC, 32'hCAFEF00D, 2, 1'b0, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h1FE, 32'h0,        1, 1'b0, 32'h0000CAFE));
        vecs.push_back(mk(4'b1111, 32'h1FE, 32'h11112222, 2, 1'b1, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h1FE, 32'h0,        1, 1'b0, 32'h00002222));
        vecs.push_back(mk(4'b1100, 32'h1FE, 32'h33330000, 1, 1'b1, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h1FE, 32'h0,        1, 1'b0, 32'h00002222));
        vecs.push_back(mk(4'b0000, 32'h000, 32'h0,        1, 1'b0, 32'h76543210));
        vecs.push_back(mk(4'b0000, 32'h1FC, 32'h0,        1, 1'b0, 32'h2222F00D));
        vecs.push_back(mk(4'b0100, 32'h1FE, 32'h00770000, RMW ? 2 : 1, 1'b1, 32'h0));
        vecs.push_back(mk(4'b0111, 32'h1FE, 32'h00771234, RMW ? 3 : 1, 1'b1, 32'h0));
        vecs.push_back(mk(4'b0000, 32'h1FE, 32'h0,        1, 1'b0, RMW ? 32'h00001234 : 32'h00002222));

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, ready_o}, 32'h1);
        chk("rst_ack",   {31'h0, ack_o},   32'h0);
        chk("rst_err",   {31'h0, err_o},   32'h0);
        chk("rst_ram_en_we", {30'h0, ram_en, ram_we}, 32'h0);
        chk("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

        // Reset while mid-transaction: MERGE with RMW, WR_HI after a committed low write without.
        addr = 32'h010; req = 1'b1;
        we   = RMW ? 4'b0101 : 4'b1111;
        data = RMW ? 32'h00110022 : 32'h5555AAAA;
        @(posedge clk); #1;
        req = 1'b0; we = 4'h0; addr = 32'h0; data = 32'h0;
        @(negedge clk);
        chk("mid_busy_ready", {31'h0, ready_o}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, ready_o}, 32'h1);
        chk("mid_rst_ram_en", {31'h0, ram_en}, 32'h0);
        @(negedge clk);
        chk("mid_rst_ack", {31'h0, ack_o}, 32'h0);
        reset_n = 1'b1;
        chk("rel_ready", {31'h0, ready_o}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rel_no_ack_%0d", c), {31'h0, ack_o}, 32'h0);
        end
        run(mk(4'b0000, 32'h010, 32'h0, 1, 1'b0, RMW ? 32'hABCC1234 : 32'hDEADAAAA), 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
